// File: rtl/aes_gcm_pkg.sv
// Shared phase codes, FSM states and counter-block helper for the AES-GCM
// phase sequencer.
package aes_gcm_pkg;

   localparam int PIPE_LATENCY_DEF = 12;

   typedef logic [0:127] blk_t;

   typedef enum logic [2:0] {
      PH_IDLE = 3'd0,
      PH_HKEY = 3'd1,
      PH_J0   = 3'd2,
      PH_AAD  = 3'd3,
      PH_PT   = 3'd4,
      PH_LEN  = 3'd5
   } phase_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HKEY,
      ST_J0,
      ST_AAD,
      ST_PT,
      ST_LEN,
      ST_DRAIN
   } state_e;

   // GCM inc32: only the low 32-bit word counts, wrapping without carry out.
   function automatic blk_t inc32(input blk_t cb);
      return {cb[0:95], cb[96:127] + 32'd1};
   endfunction

endpackage

// File: rtl/aes_gcm_phase_sequencer.sv
// Issues the HKEY / J0 / AAD / PT / LEN operand slots of one AES-GCM instance
// into a fixed-latency pipeline, then waits for the pipeline to drain.
module aes_gcm_phase_sequencer
   import aes_gcm_pkg::*;
#(
   parameter int PIPE_LATENCY = PIPE_LATENCY_DEF,
   parameter int MAX_BLOCKS_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   input  logic [0:95]             i_iv,
   input  logic [0:MAX_BLOCKS_W-1] i_aad_blocks,
   input  logic [0:MAX_BLOCKS_W-1] i_pt_blocks,
   input  logic                    i_aad_valid,
   output logic                    o_aad_ready,
   input  logic [0:127]            i_aad,
   input  logic                    i_pt_valid,
   output logic                    o_pt_ready,
   input  logic [0:127]            i_pt,
   output logic [0:2]              o_phase,
   output logic [0:127]            o_encrypted_cb,
   output logic [0:127]            o_encrypted_j0,
   output logic [0:127]            o_h,
   output logic [0:127]            o_aad,
   output logic [0:127]            o_plain_text,
   output logic [0:127]            o_instance_size,
   output logic                    o_busy,
   output logic                    o_done
);

   localparam int DW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LATENCY - 1);
   localparam logic [0:MAX_BLOCKS_W-1] ONE_BLK = MAX_BLOCKS_W'(1);

   state_e                  state_q, state_d;
   phase_e                  phase_q, phase_d;
   blk_t                    h_q, h_d, j0_q, j0_d, ecb_q, ecb_d;
   blk_t                    aad_q, aad_d, pt_q, pt_d, size_q, size_d, cb_q, cb_d;
   logic                    aad_rdy_q, aad_rdy_d, pt_rdy_q, pt_rdy_d;
   logic                    busy_q, busy_d, done_q, done_d;
   logic [0:95]             iv_q, iv_d;
   logic [0:MAX_BLOCKS_W-1] aad_blk_q, aad_blk_d, pt_blk_q, pt_blk_d;
   logic [0:MAX_BLOCKS_W-1] aad_cnt_q, aad_cnt_d, pt_cnt_q, pt_cnt_d;
   logic [DW-1:0]           drain_q, drain_d;
   logic                    aad_hs, pt_hs;

   // Ready flops track state_q exactly, so they double as the handshake gate.
   assign aad_hs = aad_rdy_q & i_aad_valid;
   assign pt_hs  = pt_rdy_q & i_pt_valid;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (i_start) state_d = ST_HKEY;
         ST_HKEY:  state_d = ST_J0;
         ST_J0: begin
            if (aad_blk_q != '0)     state_d = ST_AAD;
            else if (pt_blk_q != '0) state_d = ST_PT;
            else                     state_d = ST_LEN;
         end
         ST_AAD: begin
            if (aad_hs && aad_cnt_q == ONE_BLK)
               state_d = (pt_blk_q != '0) ? ST_PT : ST_LEN;
         end
         ST_PT:    if (pt_hs && pt_cnt_q == ONE_BLK) state_d = ST_LEN;
         ST_LEN:   state_d = ST_DRAIN;
         ST_DRAIN: if (drain_q == DRAIN_LAST) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      iv_d      = iv_q;
      aad_blk_d = aad_blk_q;
      pt_blk_d  = pt_blk_q;
      aad_cnt_d = aad_cnt_q;
      pt_cnt_d  = pt_cnt_q;
      cb_d      = cb_q;
      drain_d   = drain_q;
      phase_d   = PH_IDLE;
      h_d       = h_q;
      j0_d      = j0_q;
      ecb_d     = ecb_q;
      aad_d     = aad_q;
      pt_d      = pt_q;
      size_d    = size_q;
      done_d    = 1'b0;
      aad_rdy_d = (state_d == ST_AAD);
      pt_rdy_d  = (state_d == ST_PT);
      busy_d    = (state_d != ST_IDLE);
      unique case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               iv_d      = i_iv;
               aad_blk_d = i_aad_blocks;
               pt_blk_d  = i_pt_blocks;
               aad_cnt_d = i_aad_blocks;
               pt_cnt_d  = i_pt_blocks;
            end
         end
         ST_HKEY: begin
            phase_d = PH_HKEY;
            h_d     = '0;
         end
         ST_J0: begin
            phase_d = PH_J0;
            j0_d    = {iv_q, 32'h0000_0001};
            cb_d    = {iv_q, 32'h0000_0002};
         end
         ST_AAD: begin
            if (aad_hs) begin
               phase_d   = PH_AAD;
               aad_d     = i_aad;
               aad_cnt_d = aad_cnt_q - ONE_BLK;
            end
         end
         ST_PT: begin
            if (pt_hs) begin
               phase_d  = PH_PT;
               pt_d     = i_pt;
               ecb_d    = cb_q;
               cb_d     = inc32(cb_q);
               pt_cnt_d = pt_cnt_q - ONE_BLK;
            end
         end
         ST_LEN: begin
            phase_d = PH_LEN;
            size_d  = {64'(aad_blk_q) << 7, 64'(pt_blk_q) << 7};
         end
         ST_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               drain_d = '0;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         iv_q      <= '0;
         aad_blk_q <= '0;
         pt_blk_q  <= '0;
         aad_cnt_q <= '0;
         pt_cnt_q  <= '0;
         cb_q      <= '0;
         drain_q   <= '0;
         phase_q   <= PH_IDLE;
         h_q       <= '0;
         j0_q      <= '0;
         ecb_q     <= '0;
         aad_q     <= '0;
         pt_q      <= '0;
         size_q    <= '0;
         done_q    <= 1'b0;
         aad_rdy_q <= 1'b0;
         pt_rdy_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         iv_q      <= iv_d;
         aad_blk_q <= aad_blk_d;
         pt_blk_q  <= pt_blk_d;
         aad_cnt_q <= aad_cnt_d;
         pt_cnt_q  <= pt_cnt_d;
         cb_q      <= cb_d;
         drain_q   <= drain_d;
         phase_q   <= phase_d;
         h_q       <= h_d;
         j0_q      <= j0_d;
         ecb_q     <= ecb_d;
         aad_q     <= aad_d;
         pt_q      <= pt_d;
         size_q    <= size_d;
         done_q    <= done_d;
         aad_rdy_q <= aad_rdy_d;
         pt_rdy_q  <= pt_rdy_d;
         busy_q    <= busy_d;
      end
   end

   assign o_phase         = phase_q;
   assign o_h             = h_q;
   assign o_encrypted_j0  = j0_q;
   assign o_encrypted_cb  = ecb_q;
   assign o_aad           = aad_q;
   assign o_plain_text    = pt_q;
   assign o_instance_size = size_q;
   assign o_aad_ready     = aad_rdy_q;
   assign o_pt_ready      = pt_rdy_q;
   assign o_busy          = busy_q;
   assign o_done          = done_q;

endmodule

// File: tb/tb_aes_gcm_phase_sequencer.sv
// Directed bench for the AES-GCM phase sequencer: table of whole instances
// plus hand-written reset, held-start and counter-wrap sequences.
module tb_aes_gcm_phase_sequencer;
   import aes_gcm_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         i_start = 1'b0;
   logic [95:0]  i_iv = '0;
   logic [15:0]  i_aad_blocks = '0, i_pt_blocks = '0;
   logic         i_aad_valid = 1'b0, i_pt_valid = 1'b0;
   logic [127:0] i_aad = '0, i_pt = '0;
   logic         o_aad_ready, o_pt_ready, o_busy, o_done;
   logic [2:0]   o_phase;
   logic [127:0] o_encrypted_cb, o_encrypted_j0, o_h, o_aad, o_plain_text, o_instance_size;

   always #5 clk = ~clk;

   aes_gcm_phase_sequencer dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_iv(i_iv),
      .i_aad_blocks(i_aad_blocks), .i_pt_blocks(i_pt_blocks),
      .i_aad_valid(i_aad_valid), .o_aad_ready(o_aad_ready), .i_aad(i_aad),
      .i_pt_valid(i_pt_valid), .o_pt_ready(o_pt_ready), .i_pt(i_pt),
      .o_phase(o_phase), .o_encrypted_cb(o_encrypted_cb), .o_encrypted_j0(o_encrypted_j0),
      .o_h(o_h), .o_aad(o_aad), .o_plain_text(o_plain_text),
      .o_instance_size(o_instance_size), .o_busy(o_busy), .o_done(o_done)
   );

   typedef struct {
      logic [95:0]  iv;
      int           na;
      int           np;
      bit           tog;        // toggle i_pt_valid 1,0,1.. while in PT
      logic [47:0]  exp_ph;     // issued phases, one octal digit per slot
      int           exp_slots;
      int           exp_bub;
      logic [127:0] exp_size;
   } vec_t;

   vec_t vecs [5];
   int   n_pass = 0, n_tot = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   function automatic logic [127:0] aw(input int k);
      return {96'hA0A0_0000_1111_2222_3333_4444, 32'(k)};
   endfunction

   function automatic logic [127:0] pw(input int k);
      return {96'hB0B0_5555_6666_7777_8888_9999, 32'(k)};
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      logic [47:0] ph_log = '0;
      int nslot = 0, nbub = 0, len_c = -1, aidx = 0, pidx = 0, na_seen = 0, np_seen = 0;
      bit done_seen = 1'b0, hs_a, hs_p, tog = 1'b1;
      string tag = $sformatf("v%0d", idx);
      @(posedge clk); #1;
      i_start = 1'b1; i_iv = v.iv;
      i_aad_blocks = 16'(v.na); i_pt_blocks = 16'(v.np);
      i_aad_valid = 1'b1; i_pt_valid = 1'b1; i_aad = aw(0); i_pt = pw(0);
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int c = 0; c < 400 && !done_seen; c++) begin
         @(negedge clk);
         hs_a = o_aad_ready && i_aad_valid;
         hs_p = o_pt_ready && i_pt_valid;
         if (o_phase != 3'd0) begin
            ph_log = {ph_log[44:0], o_phase};
            nslot++;
            case (o_phase)
               3'd1: chk({tag, "_h"}, o_h, '0);
               3'd2: chk({tag, "_j0"}, o_encrypted_j0, {v.iv, 32'h1});
               3'd3: begin
                  chk({tag, "_aad"}, o_aad, aw(na_seen));
                  na_seen++;
               end
               3'd4: begin
                  chk({tag, "_pt"}, o_plain_text, pw(np_seen));
                  chk({tag, "_cb"}, o_encrypted_cb, {v.iv, 32'(2 + np_seen)});
                  np_seen++;
               end
               3'd5: begin
                  chk({tag, "_size"}, o_instance_size, v.exp_size);
                  len_c = c;
               end
               default: chk({tag, "_phase_code"}, o_phase, '0);
            endcase
         end else if (nslot > 0 && len_c < 0) begin
            nbub++;
         end
         if (o_done) begin
            done_seen = 1'b1;
            chk({tag, "_done_lat"}, c - len_c, 12);
            chk({tag, "_busy_at_done"}, o_busy, 0);
         end
         @(posedge clk); #1;
         if (hs_a) begin aidx++; i_aad = aw(aidx); end
         if (hs_p) begin pidx++; i_pt = pw(pidx); end
         if (v.tog && o_pt_ready) begin
            i_pt_valid = tog;
            tog = !tog;
         end else begin
            i_pt_valid = 1'b1;
         end
      end
      chk({tag, "_done_seen"}, done_seen, 1);
      chk({tag, "_phases"}, ph_log, v.exp_ph);
      chk({tag, "_slots"}, nslot, v.exp_slots);
      chk({tag, "_bubbles"}, nbub, v.exp_bub);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, o_done, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_phase"}, o_phase, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_rdy"}, {o_aad_ready, o_pt_ready}, 0);
      chk({tag, "_cb"}, o_encrypted_cb, 0);
      chk({tag, "_j0"}, o_encrypted_j0, 0);
      chk({tag, "_dat"}, o_aad | o_plain_text | o_h, 0);
      chk({tag, "_size"}, o_instance_size, 0);
   endtask

   initial begin
      vecs[0] = '{96'h0, 0, 0, 1'b0, 48'o125, 3, 0, 128'h0};
      vecs[1] = '{96'h0123456789abcdef00112233, 2, 3, 1'b0, 48'o12334445, 8, 0,
                  {64'd256, 64'd384}};
      vecs[2] = '{96'hffff_ffff_ffff_ffff_ffff_ffff, 0, 2, 1'b1, 48'o12445, 5, 1,
                  {64'd0, 64'd256}};
      vecs[3] = '{96'hcafe_babe_dead_beef_0000_0001, 1, 0, 1'b0, 48'o1235, 4, 0,
                  {64'd128, 64'd0}};
      vecs[4] = '{96'h5555_aaaa_5555_aaaa_5555_aaaa, 3, 1, 1'b0, 48'o1233345, 7, 0,
                  {64'd384, 64'd128}};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("rst_hold");
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero("rst_rel");

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // inc32 wrap and non-wrap on the shared helper
      begin
         logic [127:0] r;
         r = inc32({96'h0123456789abcdef00112233, 32'hFFFF_FFFF});
         chk("inc32_wrap", r, {96'h0123456789abcdef00112233, 32'h0});
         r = inc32({96'hffff_ffff_ffff_ffff_ffff_ffff, 32'hFFFF_FFFF});
         chk("inc32_wrap_ones", r, {96'hffff_ffff_ffff_ffff_ffff_ffff, 32'h0});
         r = inc32({96'h5555_aaaa_5555_aaaa_5555_aaaa, 32'h0000_0007});
         chk("inc32_plain", r, {96'h5555_aaaa_5555_aaaa_5555_aaaa, 32'h0000_0008});
      end

      // reset in the middle of PT abandons the instance
      begin
         bit seen = 1'b0;
         int ndone = 0;
         @(posedge clk); #1;
         i_start = 1'b1; i_iv = 96'h1111_2222_3333_4444_5555_6666;
         i_aad_blocks = 16'd0; i_pt_blocks = 16'd3;
         i_aad_valid = 1'b0; i_pt_valid = 1'b0; i_pt = pw(7);
         @(posedge clk); #1;
         i_start = 1'b0;
         for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (o_pt_ready) seen = 1'b1;
         end
         chk("rstmid_pt_ready", seen, 1);
         i_pt_valid = 1'b1;
         @(posedge clk); #1;
         chk("rstmid_slot", o_phase, 4);
         chk("rstmid_cb", o_encrypted_cb, {96'h1111_2222_3333_4444_5555_6666, 32'h2});
         i_pt_valid = 1'b0; rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         @(negedge clk);
         chk_all_zero("rstmid");
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_done || o_busy) ndone++;
         end
         chk("rstmid_no_done", ndone, 0);
         run_vec(vecs[1], 5);
      end

      // i_start held high through an instance
      begin
         int nh = 0;
         bit dn = 1'b0;
         @(posedge clk); #1;
         i_start = 1'b1; i_iv = 96'h2222_0000_0000_0000_0000_0000;
         i_aad_blocks = 16'd0; i_pt_blocks = 16'd0;
         for (int c = 0; c < 60 && !dn; c++) begin
            @(negedge clk);
            if (o_phase == 3'd1) nh++;
            if (o_done) dn = 1'b1;
         end
         chk("held_done", dn, 1);
         chk("held_hkey_once", nh, 1);
         @(negedge clk);
         chk("held_done_1cyc", o_done, 0);
         chk("held_restart_busy", o_busy, 1);
         @(negedge clk);
         chk("held_restart_hkey", o_phase, 1);
         i_start = 1'b0;
         dn = 1'b0;
         for (int c = 0; c < 60 && !dn; c++) begin
            @(negedge clk);
            if (o_done) dn = 1'b1;
         end
         chk("held_second_done", dn, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/aes_gcm_phase_sequencer.md
AES_GCM_PHASE_SEQUENCER -- requirements
Module: aes_gcm_phase_sequencer

Interface
REQ-001 SHALL have parameter PIPE_LATENCY, default 12: clk cycles from an issue slot to the result leaving the last pipeline stage.
REQ-002 SHALL have parameter MAX_BLOCKS_W, default 16: width of the block-count inputs.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_start  input  1  begin one GCM instance; sampled only in IDLE.
REQ-006 i_iv  input  [0:95]  96-bit IV, captured on accepted i_start.
REQ-007 i_aad_blocks, i_pt_blocks  input  [0:MAX_BLOCKS_W-1] each  AAD/plaintext block counts, captured on accepted i_start.
REQ-008 i_aad_valid / o_aad_ready / i_aad[0:127]: AAD block stream, valid/ready handshake.
REQ-009 i_pt_valid / o_pt_ready / i_pt[0:127]: plaintext block stream, valid/ready handshake.
REQ-010 o_phase  output  [0:2]  phase tag of the current issue slot.
REQ-011 o_encrypted_cb, o_encrypted_j0, o_h, o_aad, o_plain_text, o_instance_size  output  [0:127] each  pipeline-entry operands.
REQ-012 o_busy  output  1  instance in progress; o_done  output  1  one-cycle pulse when the instance has drained.

Function
REQ-013 Phase codes: 0 IDLE/bubble, 1 HKEY, 2 J0, 3 AAD, 4 PT, 5 LEN; codes 6-7 SHALL never be driven.
REQ-014 FSM states: IDLE, HKEY, J0, AAD, PT, LEN, DRAIN; all outputs registered, so the FSM-to-output latency is 1 cycle.
REQ-015 IDLE to HKEY on i_start=1; i_start in any other state is ignored.
REQ-016 HKEY: one slot, phase 1, o_h=0, then go to J0.
REQ-017 J0: one slot, phase 2, o_encrypted_j0={IV,32'h00000001}; CB register loads {IV,32'h00000002}; next state is AAD if aad_blocks>0, else PT if pt_blocks>0, else LEN.
REQ-018 AAD: o_aad_ready=1; each cycle with valid&&ready issues phase 3 with o_aad=i_aad and decrements the remaining count; after the last block go to PT (pt_blocks>0) or LEN.
REQ-019 PT: o_pt_ready=1; each handshake issues phase 4 with o_plain_text=i_pt and o_encrypted_cb=CB, then CB applies inc32 (low 32 bits +1 mod 2^32, upper 96 unchanged); after the last block go to LEN.
REQ-020 A cycle in AAD/PT without a handshake SHALL issue a bubble: phase 0, other outputs hold.
REQ-021 LEN: one slot, phase 5, o_instance_size={64-bit aad_blocks*128, 64-bit pt_blocks*128}, zero-extended; then go to DRAIN.
REQ-022 DRAIN counts PIPE_LATENCY cycles, then pulses o_done for one cycle and returns to IDLE.
REQ-023 o_busy=1 in every state except IDLE.
REQ-024 o_aad_ready=0 outside AAD; o_pt_ready=0 outside PT.
REQ-025 Low-word CB wrap 32'hFFFFFFFF to 0 SHALL leave the upper 96 bits unchanged.
REQ-026 o_h, o_encrypted_j0, o_encrypted_cb, o_aad, o_plain_text, o_instance_size SHALL each hold their last value outside their own issuing phase.

Reset
REQ-027 rst=1 forces IDLE; o_phase=0; o_busy, o_done, o_aad_ready, o_pt_ready=0; all 128-bit outputs, CB, counters and the drain timer =0.
REQ-028 rst asserted mid-instance SHALL abandon the instance with no o_done pulse; the next i_start begins a fresh instance.

Structure
REQ-029 Phase codes, the state enum, PIPE_LATENCY default and an inc32 function SHALL live in the shared package aes_gcm_pkg.
REQ-030 No sub-module is required; an optional aes_gcm_inc32 helper is permitted.

Verification
REQ-031 IV=96'h0, aad=0, pt=0, start -> phases 1,2,5; J0=32'h1 in low word; instance_size=0; o_done exactly 12 cycles after the LEN slot.
REQ-032 aad=2, pt=3, valid always high -> phases 1,2,3,3,4,4,4,5 back-to-back; CB low words 2,3,4.
REQ-033 pt=2, i_pt_valid toggling 1,0,1 -> phase sequence 4,0,4; CB advances only on handshakes.
REQ-034 IV low-word context with CB low word 32'hFFFFFFFF -> next CB low word 0, upper 96 bits unchanged.
REQ-035 rst pulsed during PT -> next cycle IDLE, all outputs 0, no o_done; new start completes normally.
REQ-036 i_start held high while busy -> no second instance until IDLE is reached.
